// File: rtl/calc_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_io_pkg
//  Description : Shared definitions for the calculator IO bus master:
//                IO window addresses, operation encodings and FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_io_pkg;

  // Memory-mapped IO window of sc_datamem
  localparam logic [31:0] c_addr_sw   = 32'hffff_ff00;
  localparam logic [31:0] c_addr_key  = 32'hffff_ff10;
  localparam logic [31:0] c_addr_hex0 = 32'hffff_ff20;
  localparam logic [31:0] c_addr_hex1 = 32'hffff_ff30;
  localparam logic [31:0] c_addr_hex2 = 32'hffff_ff40;
  localparam logic [31:0] c_addr_hex3 = 32'hffff_ff50;
  localparam logic [31:0] c_addr_hex4 = 32'hffff_ff60;
  localparam logic [31:0] c_addr_hex5 = 32'hffff_ff70;
  localparam logic [31:0] c_addr_led  = 32'hffff_ff80;

  // Operation encodings driven on the mode output
  localparam logic [1:0] c_mode_add = 2'b00;
  localparam logic [1:0] c_mode_sub = 2'b01;
  localparam logic [1:0] c_mode_xor = 2'b10;

  // Frame sequencer states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_SW  = 4'd1,
    S_RD_KEY = 4'd2,
    S_CALC   = 4'd3,
    S_WR0    = 4'd4,
    S_WR1    = 4'd5,
    S_WR2    = 4'd6,
    S_WR3    = 4'd7,
    S_WR4    = 4'd8,
    S_WR5    = 4'd9,
    S_WR_LED = 4'd10,
    S_GAP    = 4'd11
  } state_t;

  // A BCD digit occupies the low nibble of a write word, the rest is zero
  function automatic logic [31:0] digit_word(input logic [3:0] digit);
    return {28'd0, digit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_io_master_bin2bcd2.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd2
//  Description : Combinational 6-bit binary to two-digit BCD converter.
//                Inputs are < 64, so the tens digit never exceeds 6.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd2 (
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] w_tens_weight;
  logic [5:0] w_rem;

  // Tens digit by threshold compare, ones digit as the remainder
  always_comb begin
    tens = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      if (value >= 6'(10 * k)) begin
        tens = 4'(k);
      end
    end
    w_tens_weight = {2'b00, tens} * 6'd10;
    w_rem         = value - w_tens_weight;
    ones          = w_rem[3:0];
  end

endmodule
`default_nettype wire

// File: rtl/calc_io_master.sv
`default_nettype none
// ============================================================================
//  Module      : calc_io_master
//  Description : Bus initiator that replaces the CPU on sc_datamem's IO window.
//                Each frame reads switches and keys, computes A op B and writes
//                six BCD digits to the hex display registers.
//                Optional feature macro CALC_SIGN_EN: signed-magnitude subtract
//                plus an extra LED write carrying the sign.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_io_master
  import calc_io_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int POLL_GAP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        we,
  input  logic [31:0] dataout,
  output logic [1:0]  mode,
  output logic        frame_done
);

  localparam logic [15:0] c_rd_last  = 16'(RD_LAT - 1);
  localparam bit          c_has_gap  = (POLL_GAP > 0);
  localparam logic [15:0] c_gap_last = c_has_gap ? 16'(POLL_GAP - 1) : 16'd0;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [9:0]  r_sw;
  logic [2:0]  r_key;        // {key3, key2, key1}, active-low
  logic [31:0] r_addr;
  logic [31:0] r_datain;
  logic        r_we;
  logic [1:0]  r_mode;
  logic        r_frame_done;

  logic [1:0]  w_mode_next;
  logic [5:0]  w_a6;
  logic [5:0]  w_b6;
  logic [5:0]  w_result;
  logic [3:0]  w_res_tens, w_res_ones;
  logic [3:0]  w_a_tens, w_a_ones;
  logic [3:0]  w_b_tens, w_b_ones;
  state_t      w_after_state;
  logic [31:0] w_after_addr;
  logic        w_unused_dataout;

`ifdef CALC_SIGN_EN
  logic        w_neg;
`endif

  assign addr       = r_addr;
  assign datain     = r_datain;
  assign we         = r_we;
  assign mode       = r_mode;
  assign frame_done = r_frame_done;

  // Only the switch and key fields of the read word carry information
  assign w_unused_dataout = ^dataout[31:10];

  assign w_a6 = {1'b0, r_sw[9:5]};
  assign w_b6 = {1'b0, r_sw[4:0]};

  // Where the sequencer goes once a frame (and its gap) is over
  assign w_after_state = enable ? S_RD_SW : S_IDLE;
  assign w_after_addr  = enable ? c_addr_sw : 32'd0;

  // Key priority key1 > key2 > key3; no key held keeps the previous op
  always_comb begin
    w_mode_next = r_mode;
    if (!r_key[0]) begin
      w_mode_next = c_mode_add;
    end else if (!r_key[1]) begin
      w_mode_next = c_mode_sub;
    end else if (!r_key[2]) begin
      w_mode_next = c_mode_xor;
    end
  end

`ifdef CALC_SIGN_EN
  assign w_neg = (w_mode_next == c_mode_sub) && (w_a6 < w_b6);
`endif

  // Result is held stable through the write states because sw/key and the
  // (idempotent) mode decision do not change until the next RD_SW
  always_comb begin
    w_result = 6'd0;
    case (w_mode_next)
      c_mode_add: w_result = w_a6 + w_b6;
`ifdef CALC_SIGN_EN
      c_mode_sub: w_result = w_neg ? (w_b6 - w_a6) : (w_a6 - w_b6);
`else
      c_mode_sub: w_result = w_a6 - w_b6;
`endif
      c_mode_xor: w_result = w_a6 ^ w_b6;
      default:    w_result = 6'd0;
    endcase
  end

  bin2bcd2 u_bcd_res (.value(w_result), .tens(w_res_tens), .ones(w_res_ones));
  bin2bcd2 u_bcd_a   (.value(w_a6),     .tens(w_a_tens),   .ones(w_a_ones));
  bin2bcd2 u_bcd_b   (.value(w_b6),     .tens(w_b_tens),   .ones(w_b_ones));

  // Frame sequencer with registered bus outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_sw         <= 10'd0;
      r_key        <= 3'b111;
      r_addr       <= 32'd0;
      r_datain     <= 32'd0;
      r_we         <= 1'b0;
      r_mode       <= c_mode_add;
      r_frame_done <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_datain     <= 32'd0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (enable) begin
            r_state <= S_RD_SW;
            r_addr  <= c_addr_sw;
          end else begin
            r_addr  <= 32'd0;
          end
        end
        S_RD_SW: begin
          if (r_cnt == c_rd_last) begin
            r_sw    <= dataout[9:0];
            r_state <= S_RD_KEY;
            r_addr  <= c_addr_key;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        S_RD_KEY: begin
          if (r_cnt == c_rd_last) begin
            r_key   <= dataout[3:1];
            r_state <= S_CALC;
            r_addr  <= 32'd0;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        S_CALC: begin
          r_mode   <= w_mode_next;
          r_state  <= S_WR0;
          r_addr   <= c_addr_hex0;
          r_datain <= digit_word(w_res_ones);
          r_we     <= 1'b1;
        end
        S_WR0: begin
          r_state  <= S_WR1;
          r_addr   <= c_addr_hex1;
          r_datain <= digit_word(w_res_tens);
          r_we     <= 1'b1;
        end
        S_WR1: begin
          r_state  <= S_WR2;
          r_addr   <= c_addr_hex2;
          r_datain <= digit_word(w_b_ones);
          r_we     <= 1'b1;
        end
        S_WR2: begin
          r_state  <= S_WR3;
          r_addr   <= c_addr_hex3;
          r_datain <= digit_word(w_b_tens);
          r_we     <= 1'b1;
        end
        S_WR3: begin
          r_state  <= S_WR4;
          r_addr   <= c_addr_hex4;
          r_datain <= digit_word(w_a_ones);
          r_we     <= 1'b1;
        end
        S_WR4: begin
          r_state  <= S_WR5;
          r_addr   <= c_addr_hex5;
          r_datain <= digit_word(w_a_tens);
          r_we     <= 1'b1;
`ifndef CALC_SIGN_EN
          r_frame_done <= 1'b1;
`endif
        end
`ifdef CALC_SIGN_EN
        S_WR5: begin
          r_state      <= S_WR_LED;
          r_addr       <= c_addr_led;
          r_datain     <= {31'd0, w_neg};
          r_we         <= 1'b1;
          r_frame_done <= 1'b1;
        end
        S_WR_LED: begin
`else
        S_WR5, S_WR_LED: begin
`endif
          r_cnt <= 16'd0;
          if (c_has_gap) begin
            r_state <= S_GAP;
            r_addr  <= 32'd0;
          end else begin
            r_state <= w_after_state;
            r_addr  <= w_after_addr;
          end
        end
        S_GAP: begin
          if (r_cnt == c_gap_last) begin
            r_state <= w_after_state;
            r_addr  <= w_after_addr;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= 32'd0;
          r_cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_io_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_io_master
//  Description : Self-checking bench for calc_io_master. Two instances: the
//                default timing (RD_LAT=1, POLL_GAP=4) and RD_LAT=3/POLL_GAP=0.
//                A behavioural sc_datamem slave returns garbage except on the
//                last cycle of each read, and a frame model predicts all writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_io_master;

  localparam logic [31:0] A_SW   = 32'hffff_ff00;
  localparam logic [31:0] A_KEY  = 32'hffff_ff10;
  localparam logic [31:0] A_HEX0 = 32'hffff_ff20;
  localparam logic [31:0] A_LED  = 32'hffff_ff80;

  // Key bus values dataout[3:1] = {key3, key2, key1}, active-low
  localparam logic [2:0] K_ADD  = 3'b110;
  localparam logic [2:0] K_SUB  = 3'b101;
  localparam logic [2:0] K_XOR  = 3'b011;
  localparam logic [2:0] K_NONE = 3'b111;
  localparam logic [2:0] K_ALL  = 3'b000;

`ifdef CALC_SIGN_EN
  localparam int N_WR = 7;
`else
  localparam int N_WR = 6;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        en     [2];
  logic [31:0] addr_w [2];
  logic [31:0] din_w  [2];
  logic        we_w   [2];
  logic [31:0] dout_w [2];
  logic [1:0]  mode_w [2];
  logic        fd_w   [2];

  int          lat      [2];
  int          exp_len  [2];
  logic [9:0]  sw_v     [2];
  logic [2:0]  key_v    [2];
  logic [31:0] last_a   [2];
  int          hold     [2];
  int          fd_cnt   [2];
  int          fd_cyc   [2];
  int          fd_prev  [2];
  logic [31:0] fd_addr  [2];

  int          cyc;
  int          act;
  int          n_checks;
  int          n_fail;
  logic [1:0]  mdl_mode;
  wr_t         wq[$];
  wr_t         eq[$];

  calc_io_master #(.RD_LAT(1), .POLL_GAP(4)) dut (
    .clock(clk), .reset(reset), .enable(en[0]), .addr(addr_w[0]),
    .datain(din_w[0]), .we(we_w[0]), .dataout(dout_w[0]),
    .mode(mode_w[0]), .frame_done(fd_w[0])
  );

  calc_io_master #(.RD_LAT(3), .POLL_GAP(0)) dut_b2b (
    .clock(clk), .reset(reset), .enable(en[1]), .addr(addr_w[1]),
    .datain(din_w[1]), .we(we_w[1]), .dataout(dout_w[1]),
    .mode(mode_w[1]), .frame_done(fd_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave model and bus monitor, evaluated mid-cycle while the bus is stable
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      logic [31:0] tv;
      if (addr_w[id] == last_a[id]) hold[id]++;
      else hold[id] = 1;
      last_a[id] = addr_w[id];
      tv = $urandom;
      if (addr_w[id] == A_SW)       tv = {tv[31:10], sw_v[id]};
      else if (addr_w[id] == A_KEY) tv = {tv[31:4], key_v[id], tv[0]};
      dout_w[id] = (hold[id] == lat[id]) ? tv : ~tv;
      if (we_w[id]) begin
        if (id == act) wq.push_back('{a: addr_w[id], d: din_w[id]});
      end else begin
        check("idle_datain", din_w[id], 32'd0);
      end
      if (fd_w[id]) begin
        fd_cnt[id]++;
        fd_prev[id] = fd_cyc[id];
        fd_cyc[id]  = cyc;
        fd_addr[id] = addr_w[id];
      end
    end
  end

  // Reference frame: operand split, op selection and decimal digits
  task automatic expect_frame(input logic [9:0] sw, input logic [2:0] k);
    int a, b, r, neg;
    a = int'(sw[9:5]);
    b = int'(sw[4:0]);
    neg = 0;
    if (!k[0])      mdl_mode = 2'b00;
    else if (!k[1]) mdl_mode = 2'b01;
    else if (!k[2]) mdl_mode = 2'b10;
    case (mdl_mode)
      2'b00:   r = a + b;
`ifdef CALC_SIGN_EN
      2'b01:   begin neg = (a < b) ? 1 : 0; r = (a < b) ? b - a : a - b; end
`else
      2'b01:   r = (a - b + 64) % 64;
`endif
      default: r = a ^ b;
    endcase
    eq.delete();
    eq.push_back('{a: A_HEX0,         d: 32'(r % 10)});
    eq.push_back('{a: A_HEX0 + 32'h10, d: 32'(r / 10)});
    eq.push_back('{a: A_HEX0 + 32'h20, d: 32'(b % 10)});
    eq.push_back('{a: A_HEX0 + 32'h30, d: 32'(b / 10)});
    eq.push_back('{a: A_HEX0 + 32'h40, d: 32'(a % 10)});
    eq.push_back('{a: A_HEX0 + 32'h50, d: 32'(a / 10)});
`ifdef CALC_SIGN_EN
    eq.push_back('{a: A_LED, d: 32'(neg)});
`endif
  endtask

  task automatic set_frame(input int id, input logic [9:0] sw, input logic [2:0] k);
    sw_v[id]  = sw;
    key_v[id] = k;
    expect_frame(sw, k);
    wq.delete();
  endtask

  task automatic wait_frame(input int id, input bit do_len);
    int start;
    bit got;
    start = fd_cnt[id];
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (fd_cnt[id] != start) begin got = 1'b1; break; end
    end
    check("frame_done_seen", 32'(got), 32'd1);
    check("n_writes", 32'(wq.size()), 32'(N_WR));
    for (int i = 0; i < N_WR && i < wq.size(); i++) begin
      check($sformatf("wr%0d_addr", i), wq[i].a, eq[i].a);
      check($sformatf("wr%0d_data", i), wq[i].d, eq[i].d);
    end
    check("mode", 32'(mode_w[id]), 32'(mdl_mode));
    check("frame_done_addr", fd_addr[id], eq[N_WR-1].a);
    if (do_len) check("frame_len", 32'(fd_cyc[id] - fd_prev[id]), 32'(exp_len[id]));
  endtask

  task automatic run_frame(input int id, input logic [9:0] sw, input logic [2:0] k, input bit do_len);
    set_frame(id, sw, k);
    wait_frame(id, do_len);
  endtask

  initial begin
    logic [9:0] sw0;
    bit ok;
    bit bad;
    n_checks = 0; n_fail = 0; cyc = 0; act = 0; mdl_mode = 2'b00;
    lat[0] = 1; lat[1] = 3;
    exp_len[0] = 2*1 + 1 + N_WR + 4;
    exp_len[1] = 2*3 + 1 + N_WR + 0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; sw_v[i] = '0; key_v[i] = K_NONE; last_a[i] = '0;
      hold[i] = 0; fd_cnt[i] = 0; fd_cyc[i] = 0; fd_prev[i] = 0; fd_addr[i] = '0;
      dout_w[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", addr_w[0], 32'd0);
    check("rst_we", 32'(we_w[0]), 32'd0);
    check("rst_mode", 32'(mode_w[0]), 32'd0);
    check("rst_frame_done", 32'(fd_w[0]), 32'd0);
    check("rst_datain", din_w[0], 32'd0);
    reset = 1'b0;

    // Directed frames: A=3, B=5
    sw0 = 10'b00011_00101;
    set_frame(0, sw0, K_ADD);
    en[0] = 1'b1;
    wait_frame(0, 1'b0);
    run_frame(0, sw0, K_SUB,  1'b1);
    run_frame(0, sw0, K_XOR,  1'b1);
    run_frame(0, sw0, K_NONE, 1'b1);
    run_frame(0, sw0, K_ALL,  1'b1);
    run_frame(0, 10'h3ff, K_ADD, 1'b1);

    // Asynchronous reset in the middle of WR3
    set_frame(0, 10'($urandom_range(0, 1023)), K_NONE);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (we_w[0] && addr_w[0] == A_HEX0 + 32'h30) begin ok = 1'b1; break; end
    end
    check("reach_wr3", 32'(ok), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_we", 32'(we_w[0]), 32'd0);
    check("midrst_addr", addr_w[0], 32'd0);
    check("midrst_mode", 32'(mode_w[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl_mode = 2'b00;
    expect_frame(sw_v[0], K_NONE);
    wq.delete();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (addr_w[0] != 32'd0) begin ok = 1'b1; break; end
    end
    check("post_rst_first_addr", ok ? addr_w[0] : 32'd0, A_SW);
    wait_frame(0, 1'b0);

    // Randomized frames on the default instance
    for (int n = 0; n < 25; n++) begin
      run_frame(0, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'b1);
    end
    en[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("dut0_parked_addr", addr_w[0], 32'd0);

    // Back-to-back instance with a 3-cycle read latency
    act = 1;
    mdl_mode = 2'b00;
    set_frame(1, 10'($urandom_range(0, 1023)), K_SUB);
    en[1] = 1'b1;
    wait_frame(1, 1'b0);
    for (int n = 0; n < 10; n++) begin
      run_frame(1, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'b1);
    end

    // Drop enable early in a frame: it must complete, then park
    set_frame(1, 10'($urandom_range(0, 1023)), K_XOR);
    repeat (3) @(negedge clk);
    en[1] = 1'b0;
    wait_frame(1, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (we_w[1] || addr_w[1] != 32'd0 || fd_w[1]) bad = 1'b1;
    end
    check("parked_idle", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
